// File: rtl/memory_arbiter_pkg.sv
// Shared encodings and defaults for the main-memory arbiter between the L1 caches and the RAM.
package memory_arbiter_pkg;

    localparam int unsigned LINE_WIDTH_DEFAULT    = 128;
    localparam int unsigned PHYS_ADDR_SIZE        = 20;
    localparam int unsigned LINE_ADDR_START_INDEX = 4;
    localparam int unsigned MEM_LATENCY_DEFAULT   = 5;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_WAIT   = 2'd1;
    localparam logic [1:0] ARB_ACCESS = 2'd2;
    localparam logic [1:0] ARB_RESP   = 2'd3;

    localparam logic CLIENT_I = 1'b0;
    localparam logic CLIENT_D = 1'b1;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Counter only ever holds MEM_LATENCY-1 down to 0.
    function automatic int unsigned counter_width(input int unsigned latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_arbiter_2.sv
// Two-request round-robin picker: on a tie the client not granted last time wins.
module rr_arbiter_2
    import memory_arbiter_pkg::*;
(
    input  logic req_d,
    input  logic req_i,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    always_comb begin
        grant_valid = req_d | req_i;
        grant       = CLIENT_I;
        if (req_d && req_i) begin
            grant = (last_grant == CLIENT_I) ? CLIENT_D : CLIENT_I;
        end else if (req_d) begin
            grant = CLIENT_D;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises i_cache fills and d_cache fills/writebacks onto one synchronous RAM port,
// modelling memory latency with a down-counter before the single line-wide access.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WIDTH       = LINE_WIDTH_DEFAULT,
    parameter int unsigned ADDR_WIDTH       = PHYS_ADDR_SIZE,
    parameter int unsigned LINE_OFFSET_BITS = LINE_ADDR_START_INDEX,
    parameter int unsigned MEM_LATENCY      = MEM_LATENCY_DEFAULT
) (
    input  logic                               clock,
    input  logic                               reset,

    input  logic                               d_cache_miss,
    input  logic                               d_write_to_memory,
    input  logic [ADDR_WIDTH-1:0]              d_address,
    input  logic [LINE_WIDTH-1:0]              d_out_data,
    output logic [LINE_WIDTH-1:0]              d_fill_data,
    output logic                               d_fill_enable,
    output logic                               d_write_completed,

    input  logic                               i_cache_miss,
    input  logic [ADDR_WIDTH-1:0]              i_address,
    output logic [LINE_WIDTH-1:0]              i_fill_data,
    output logic                               i_fill_enable,

    output logic                               mem_en,
    output logic                               mem_we,
    output logic [ADDR_WIDTH-LINE_OFFSET_BITS-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0]              mem_wdata,
    input  logic [LINE_WIDTH-1:0]              mem_rdata
);

    localparam int unsigned LINE_IDX_WIDTH = ADDR_WIDTH - LINE_OFFSET_BITS;
    localparam int unsigned CW             = counter_width(MEM_LATENCY);

    logic [1:0]                state;
    logic [CW-1:0]             counter;
    logic                      last_grant;
    logic                      cur_client;
    logic                      cur_op;
    logic [LINE_IDX_WIDTH-1:0] cur_line;
    logic [LINE_WIDTH-1:0]     cur_wdata;
    logic [LINE_WIDTH-1:0]     d_fill_hold;
    logic [LINE_WIDTH-1:0]     i_fill_hold;

    logic grant_valid;
    logic grant;
    logic resp_read;

    logic unused_offset_bits;
    assign unused_offset_bits = ^{d_address[LINE_OFFSET_BITS-1:0], i_address[LINE_OFFSET_BITS-1:0]};

    rr_arbiter_2 u_rr_arbiter_2 (
        .req_d       (d_cache_miss | d_write_to_memory),
        .req_i       (i_cache_miss),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            counter     <= '0;
            last_grant  <= CLIENT_I;
            cur_client  <= CLIENT_I;
            cur_op      <= READ;
            cur_line    <= '0;
            cur_wdata   <= '0;
            d_fill_hold <= '0;
            i_fill_hold <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        cur_client <= grant;
                        last_grant <= grant;
                        // A pending writeback goes before the refill of the same client.
                        cur_op     <= (grant == CLIENT_D && d_write_to_memory) ? WRITE : READ;
                        cur_line   <= (grant == CLIENT_D) ? d_address[ADDR_WIDTH-1:LINE_OFFSET_BITS]
                                                          : i_address[ADDR_WIDTH-1:LINE_OFFSET_BITS];
                        cur_wdata  <= (grant == CLIENT_D) ? d_out_data : '0;
                        if (MEM_LATENCY == 0) begin
                            state <= ARB_ACCESS;
                        end else begin
                            state   <= ARB_WAIT;
                            counter <= CW'(MEM_LATENCY - 1);
                        end
                    end
                end
                ARB_WAIT: begin
                    if (counter == '0) begin
                        state <= ARB_ACCESS;
                    end else begin
                        counter <= counter - CW'(1);
                    end
                end
                ARB_ACCESS: begin
                    state <= ARB_RESP;
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                    if (cur_op == READ && cur_client == CLIENT_D) begin
                        d_fill_hold <= mem_rdata;
                    end
                    if (cur_op == READ && cur_client == CLIENT_I) begin
                        i_fill_hold <= mem_rdata;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // RAM read data arrives during RESP, so fill data is passed through then and held afterwards.
    always_comb begin
        mem_en            = (state == ARB_ACCESS);
        mem_we            = mem_en && (cur_op == WRITE);
        mem_addr          = cur_line;
        mem_wdata         = cur_wdata;
        resp_read         = (state == ARB_RESP) && (cur_op == READ);
        d_fill_enable     = resp_read && (cur_client == CLIENT_D);
        i_fill_enable     = resp_read && (cur_client == CLIENT_I);
        d_write_completed = (state == ARB_RESP) && (cur_op == WRITE);
        d_fill_data       = d_fill_enable ? mem_rdata : d_fill_hold;
        i_fill_data       = i_fill_enable ? mem_rdata : i_fill_hold;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: latency-3 instance plus a zero-latency instance.
`timescale 1ns/1ps
module tb_memory_arbiter;

    localparam int unsigned LW  = 128;
    localparam int unsigned AW  = 20;
    localparam int unsigned MAW = 16;

    localparam int unsigned EV_MEM_RD = 0;
    localparam int unsigned EV_MEM_WR = 1;
    localparam int unsigned EV_D_FILL = 2;
    localparam int unsigned EV_I_FILL = 3;
    localparam int unsigned EV_D_WC   = 4;

    typedef struct {
        int unsigned    cyc;
        int unsigned    kind;
        logic [LW-1:0]  data;
        logic [MAW-1:0] addr;
    } ev_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;
    ev_t q_main[$];
    ev_t q_zero[$];

    // latency-3 instance
    logic           d_cache_miss, d_write_to_memory, i_cache_miss;
    logic [AW-1:0]  d_address, i_address;
    logic [LW-1:0]  d_out_data, d_fill_data, i_fill_data, mem_wdata;
    logic [LW-1:0]  mem_rdata = '0;
    logic           d_fill_enable, d_write_completed, i_fill_enable, mem_en, mem_we;
    logic [MAW-1:0] mem_addr;

    // zero-latency instance (i side only)
    logic           z_i_cache_miss;
    logic [AW-1:0]  z_i_address;
    logic [LW-1:0]  z_d_fill_data, z_i_fill_data, z_mem_wdata;
    logic [LW-1:0]  z_mem_rdata = '0;
    logic           z_d_fill_enable, z_d_write_completed, z_i_fill_enable, z_mem_en, z_mem_we;
    logic [MAW-1:0] z_mem_addr;

    memory_arbiter #(.MEM_LATENCY(3)) dut (
        .clock(clock), .reset(reset),
        .d_cache_miss(d_cache_miss), .d_write_to_memory(d_write_to_memory),
        .d_address(d_address), .d_out_data(d_out_data),
        .d_fill_data(d_fill_data), .d_fill_enable(d_fill_enable),
        .d_write_completed(d_write_completed),
        .i_cache_miss(i_cache_miss), .i_address(i_address),
        .i_fill_data(i_fill_data), .i_fill_enable(i_fill_enable),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    memory_arbiter #(.MEM_LATENCY(0)) dut0 (
        .clock(clock), .reset(reset),
        .d_cache_miss(1'b0), .d_write_to_memory(1'b0),
        .d_address('0), .d_out_data('0),
        .d_fill_data(z_d_fill_data), .d_fill_enable(z_d_fill_enable),
        .d_write_completed(z_d_write_completed),
        .i_cache_miss(z_i_cache_miss), .i_address(z_i_address),
        .i_fill_data(z_i_fill_data), .i_fill_enable(z_i_fill_enable),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
    );

    // synchronous RAM models
    logic [LW-1:0] ram   [logic [MAW-1:0]];
    logic [LW-1:0] z_ram [logic [MAW-1:0]];

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : '0;
        end
        if (z_mem_en) begin
            if (z_mem_we) z_ram[z_mem_addr] = z_mem_wdata;
            else z_mem_rdata <= z_ram.exists(z_mem_addr) ? z_ram[z_mem_addr] : '0;
        end
    end

    task automatic push(input bit zero, input int unsigned c, input int unsigned kind,
                        input logic [LW-1:0] data, input logic [MAW-1:0] addr);
        ev_t e;
        e.cyc = c; e.kind = kind; e.data = data; e.addr = addr;
        if (zero) q_zero.push_back(e);
        else q_main.push_back(e);
    endtask

    task automatic observe(input bit zero, input int unsigned kind,
                           input logic [LW-1:0] data, input logic [MAW-1:0] addr);
        ev_t e;
        checks++;
        if ((zero && q_zero.size() == 0) || (!zero && q_main.size() == 0)) begin
            fails++;
            $display("FAIL %s event: got kind=%0d cyc=%0d addr=%h data=%h, required no event",
                     zero ? "zero" : "main", kind, cyc, addr, data);
            return;
        end
        e = zero ? q_zero.pop_front() : q_main.pop_front();
        if (kind !== e.kind || cyc !== e.cyc || data !== e.data || addr !== e.addr) begin
            fails++;
            $display("FAIL %s event: got kind=%0d cyc=%0d addr=%h data=%h, required kind=%0d cyc=%0d addr=%h data=%h",
                     zero ? "zero" : "main", kind, cyc, addr, data, e.kind, e.cyc, e.addr, e.data);
        end
    endtask

    // monitor: every strobe or pulse the DUTs present is matched against the scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_en) observe(1'b0, mem_we ? EV_MEM_WR : EV_MEM_RD, mem_we ? mem_wdata : '0, mem_addr);
            if (d_fill_enable) observe(1'b0, EV_D_FILL, d_fill_data, '0);
            if (i_fill_enable) observe(1'b0, EV_I_FILL, i_fill_data, '0);
            if (d_write_completed) observe(1'b0, EV_D_WC, '0, '0);
            if (z_mem_en) observe(1'b1, z_mem_we ? EV_MEM_WR : EV_MEM_RD, z_mem_we ? z_mem_wdata : '0, z_mem_addr);
            if (z_d_fill_enable) observe(1'b1, EV_D_FILL, z_d_fill_data, '0);
            if (z_i_fill_enable) observe(1'b1, EV_I_FILL, z_i_fill_data, '0);
            if (z_d_write_completed) observe(1'b1, EV_D_WC, '0, '0);
        end
    end

    task automatic check_eq(input string name, input logic [LW-1:0] got, input logic [LW-1:0] req);
        checks++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_strobes"}, LW'({d_fill_enable, i_fill_enable, d_write_completed, mem_en, mem_we}), '0);
        check_eq({tag, "_z_strobes"}, LW'({z_d_fill_enable, z_i_fill_enable, z_d_write_completed, z_mem_en, z_mem_we}), '0);
        check_eq({tag, "_d_fill_data"}, d_fill_data, '0);
        check_eq({tag, "_i_fill_data"}, i_fill_data, '0);
        check_eq({tag, "_mem_addr"}, LW'(mem_addr), '0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, '0);
    endtask

    logic [LW-1:0] pat_a, pat_w, pat_1, pat_2, pat_3, pat_4, pat_5;
    int unsigned t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pat_a = {8{16'hAAAA}};
        pat_w = {4{32'h1234_5678}};
        pat_1 = {4{32'hD1D1_0020}};
        pat_2 = {4{32'h1111_0030}};
        pat_3 = {4{32'hD4D4_0040}};
        pat_4 = {4{32'hD6D6_0050}};
        pat_5 = {4{32'h5555_0060}};
        ram[16'h0004] = pat_a;
        ram[16'h0020] = pat_1;
        ram[16'h0030] = pat_2;
        ram[16'h0040] = pat_3;
        ram[16'h0050] = pat_4;
        z_ram[16'h0060] = pat_5;

        reset = 1'b1;
        d_cache_miss = 1'b0; d_write_to_memory = 1'b0; i_cache_miss = 1'b0;
        d_address = '0; i_address = '0; d_out_data = '0;
        z_i_cache_miss = 1'b0; z_i_address = '0;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(1);

        // 1: single d_cache fill
        t = cyc;
        d_cache_miss = 1'b1; d_address = 20'h00040;
        push(1'b0, t + 4, EV_MEM_RD, '0, 16'h0004);
        push(1'b0, t + 5, EV_D_FILL, pat_a, '0);
        tick(6);
        d_cache_miss = 1'b0;
        check_eq("t1_fill_hold", d_fill_data, pat_a);

        // 2: writeback and fill together, writeback first
        t = cyc;
        d_write_to_memory = 1'b1; d_cache_miss = 1'b1;
        d_address = 20'h00100; d_out_data = pat_w;
        push(1'b0, t + 4, EV_MEM_WR, pat_w, 16'h0010);
        push(1'b0, t + 5, EV_D_WC, '0, '0);
        push(1'b0, t + 10, EV_MEM_RD, '0, 16'h0010);
        push(1'b0, t + 11, EV_D_FILL, pat_w, '0);
        tick(6);
        d_write_to_memory = 1'b0;
        tick(6);
        d_cache_miss = 1'b0;

        // 3: both caches miss continuously from reset; D wins the first tie
        reset = 1'b1;
        d_cache_miss = 1'b1; d_address = 20'h00200;
        i_cache_miss = 1'b1; i_address = 20'h00300;
        tick(2);
        reset = 1'b0;
        t = cyc;
        push(1'b0, t + 4, EV_MEM_RD, '0, 16'h0020);
        push(1'b0, t + 5, EV_D_FILL, pat_1, '0);
        push(1'b0, t + 10, EV_MEM_RD, '0, 16'h0030);
        push(1'b0, t + 11, EV_I_FILL, pat_2, '0);
        push(1'b0, t + 16, EV_MEM_RD, '0, 16'h0020);
        push(1'b0, t + 17, EV_D_FILL, pat_1, '0);
        tick(13);
        d_cache_miss = 1'b0; i_cache_miss = 1'b0;
        tick(5);
        check_eq("t3_d_fill_hold", d_fill_data, pat_1);
        check_eq("t3_i_fill_hold", i_fill_data, pat_2);

        // 4: reset during WAIT aborts silently; re-held request then completes
        t = cyc;
        d_cache_miss = 1'b1; d_address = 20'h00400;
        tick(2);
        reset = 1'b1;
        #1;
        check_reset_outputs("t4_abort");
        tick(2);
        reset = 1'b0;
        t = cyc;
        push(1'b0, t + 4, EV_MEM_RD, '0, 16'h0040);
        push(1'b0, t + 5, EV_D_FILL, pat_3, '0);
        tick(6);
        d_cache_miss = 1'b0;

        // 6: request dropped and address changed mid-transaction
        t = cyc;
        d_cache_miss = 1'b1; d_address = 20'h00500;
        push(1'b0, t + 4, EV_MEM_RD, '0, 16'h0050);
        push(1'b0, t + 5, EV_D_FILL, pat_4, '0);
        tick(2);
        d_cache_miss = 1'b0; d_address = 20'h00700;
        tick(4);

        // 5: zero-latency instance
        t = cyc;
        z_i_cache_miss = 1'b1; z_i_address = 20'h00600;
        push(1'b1, t + 1, EV_MEM_RD, '0, 16'h0060);
        push(1'b1, t + 2, EV_I_FILL, pat_5, '0);
        tick(3);
        z_i_cache_miss = 1'b0;
        tick(1);
        check_eq("t5_i_fill_hold", z_i_fill_data, pat_5);

        for (int i = 0; i < 50 && (q_main.size() != 0 || q_zero.size() != 0); i++) tick(1);
        checks++;
        if (q_main.size() != 0 || q_zero.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d main and %0d zero events outstanding, required 0",
                     q_main.size(), q_zero.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
